// File: rtl/rfifo_pack_if.sv
// rtl/rfifo_pack_if.sv - write/read handshake bundle for the halfword-packing FIFO
interface rfifo_pack_if #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int DEPTH          = 64
);
  localparam int R = DATA_BUS_WIDTH / 16;
  localparam int L = $clog2(DEPTH) + 1;

  logic [15:0]               fifo_wr_din;
  logic                      fifo_wr_last;
  logic                      fifo_wr_ena;
  logic                      fifo_wr_full;
  logic                      fifo_wr_ovf;
  logic [DATA_BUS_WIDTH-1:0] fifo_rd_dout;
  logic [R-1:0]              fifo_rd_strb;
  logic                      fifo_rd_last;
  logic                      fifo_rd_en;
  logic                      fifo_rd_empty;
  logic [L-1:0]              fifo_rd_level;

  modport slave (
    input  fifo_wr_din, fifo_wr_last, fifo_wr_ena, fifo_rd_en,
    output fifo_wr_full, fifo_wr_ovf, fifo_rd_dout, fifo_rd_strb,
           fifo_rd_last, fifo_rd_empty, fifo_rd_level
  );

  modport master (
    output fifo_wr_din, fifo_wr_last, fifo_wr_ena, fifo_rd_en,
    input  fifo_wr_full, fifo_wr_ovf, fifo_rd_dout, fifo_rd_strb,
           fifo_rd_last, fifo_rd_empty, fifo_rd_level
  );
endinterface

// File: rtl/rfifo_pack.sv
// rtl/rfifo_pack.sv - packs 16-bit writes into DATA_BUS_WIDTH words and queues them
// RFIFO_PACK_FWFT_EN selects first-word fall-through reads; default is standard reads.
module rfifo_pack #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int DEPTH          = 64
) (
  input  logic        fifo_clk,
  input  logic        fifo_arst_n,
  rfifo_pack_if.slave bus
);
  localparam int R  = DATA_BUS_WIDTH / 16;
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int L  = AW + 1;

  if (!(DATA_BUS_WIDTH == 16 || DATA_BUS_WIDTH == 32 ||
        DATA_BUS_WIDTH == 64 || DATA_BUS_WIDTH == 128)) begin : g_bad_width
    $error("rfifo_pack: DATA_BUS_WIDTH must be 16, 32, 64 or 128");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rfifo_pack: DEPTH must be a power of two, at least 4");
  end

  logic [LW-1:0]             r_lane;
  logic [DATA_BUS_WIDTH-1:0] r_asm;
  logic [R-1:0]              r_asm_strb;
  logic [DATA_BUS_WIDTH-1:0] r_mem_data [DEPTH];
  logic [R-1:0]              r_mem_strb [DEPTH];
  logic                      r_mem_last [DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [L-1:0]              r_level;
  logic                      r_full;
  logic                      r_empty;
  logic                      r_ovf;
  logic [DATA_BUS_WIDTH-1:0] r_dout;
  logic [R-1:0]              r_strb;
  logic                      r_last;

  logic                      w_acc;
  logic                      w_commit;
  logic                      w_pop;
  logic                      w_rd;
  logic                      w_empty_nxt;
  logic [DATA_BUS_WIDTH-1:0] w_word;
  logic [R-1:0]              w_wstrb;
  logic [L-1:0]              w_level_nxt;

  assign w_acc       = bus.fifo_wr_ena & ~r_full;
  assign w_commit    = w_acc & ((r_lane == LW'(R - 1)) | bus.fifo_wr_last);
  assign w_word      = r_asm | (DATA_BUS_WIDTH'(bus.fifo_wr_din) << {r_lane, 4'b0000});
  assign w_wstrb     = r_asm_strb | (R'(1) << r_lane);
  assign w_pop       = bus.fifo_rd_en & ~r_empty;
  assign w_level_nxt = r_level + L'(w_commit) - L'(w_pop);

`ifdef RFIFO_PACK_FWFT_EN
  // r_mcnt counts words still in storage; the output stage word is tracked by ~r_empty.
  logic [L-1:0] r_mcnt;
  assign w_rd        = (r_empty | w_pop) & (r_mcnt != '0);
  assign w_empty_nxt = ~(w_rd | (~r_empty & ~w_pop));

  always_ff @(posedge fifo_clk or negedge fifo_arst_n) begin
    if (!fifo_arst_n) begin
      r_mcnt <= '0;
    end else begin
      r_mcnt <= r_mcnt + L'(w_commit) - L'(w_rd);
    end
  end
`else
  assign w_rd        = w_pop;
  assign w_empty_nxt = (w_level_nxt == '0);
`endif

  always_ff @(posedge fifo_clk) begin
    if (w_commit) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_strb[r_wr_ptr] <= w_wstrb;
      r_mem_last[r_wr_ptr] <= bus.fifo_wr_last;
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_arst_n) begin
    if (!fifo_arst_n) begin
      r_lane     <= '0;
      r_asm      <= '0;
      r_asm_strb <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_ovf      <= 1'b0;
      r_dout     <= '0;
      r_strb     <= '0;
      r_last     <= 1'b0;
    end else begin
      r_ovf <= bus.fifo_wr_ena & r_full;
      if (w_commit) begin
        r_lane     <= '0;
        r_asm      <= '0;
        r_asm_strb <= '0;
        r_wr_ptr   <= r_wr_ptr + AW'(1);
      end else if (w_acc) begin
        r_lane     <= r_lane + LW'(1);
        r_asm      <= w_word;
        r_asm_strb <= w_wstrb;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= r_mem_data[r_rd_ptr];
        r_strb   <= r_mem_strb[r_rd_ptr];
        r_last   <= r_mem_last[r_rd_ptr];
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == L'(DEPTH));
      r_empty <= w_empty_nxt;
    end
  end

  assign bus.fifo_wr_full  = r_full;
  assign bus.fifo_wr_ovf   = r_ovf;
  assign bus.fifo_rd_dout  = r_dout;
  assign bus.fifo_rd_strb  = r_strb;
  assign bus.fifo_rd_last  = r_last;
  assign bus.fifo_rd_empty = r_empty;
  assign bus.fifo_rd_level = r_level;
endmodule

// File: doc/rfifo_pack.md
RFIFO_PACK -- requirements
Module: rfifo_pack

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 32: read-side word width in bits; legal values 16, 32, 64, 128; R = DATA_BUS_WIDTH/16 lanes per word.
REQ-002 Parameter DEPTH, default 64: storage capacity in read-side words; power of two, minimum 4; L = clog2(DEPTH)+1.
REQ-003 fifo_clk  input  1  single clock for both write and read sides.
REQ-004 fifo_arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_wr_din  input  16  write halfword.
REQ-006 fifo_wr_last  input  1  marks the final halfword of a burst.
REQ-007 fifo_wr_ena  input  1  write strobe.
REQ-008 fifo_wr_full  output  1  storage full; writes are refused.
REQ-009 fifo_wr_ovf  output  1  one-cycle pulse when a write is dropped.
REQ-010 fifo_rd_dout  output  DATA_BUS_WIDTH  read word.
REQ-011 fifo_rd_strb  output  R  per-lane valid mask for fifo_rd_dout.
REQ-012 fifo_rd_last  output  1  word holds the final halfword of a burst.
REQ-013 fifo_rd_en  input  1  read strobe.
REQ-014 fifo_rd_empty  output  1  no word available.
REQ-015 fifo_rd_level  output  L  number of committed words not yet popped.

Function
REQ-016 Packing: the k-th accepted halfword of a word, k=0..R-1, lands in fifo_rd_dout[16k+15:16k]; lane counter advances per accepted write.
REQ-017 Commit: on an accepted write with lane==R-1 or fifo_wr_last=1, the assembled word is written to storage in the same cycle; lane counter returns to 0.
REQ-018 Partial word: on commit, unfilled lanes are zero, strb bit k=1 only for filled lanes, stored last flag equals fifo_wr_last.
REQ-019 Accept rule: write accepted when fifo_wr_ena=1 and fifo_wr_full=0; fifo_wr_ena=1 with fifo_wr_full=1 drops the halfword, leaves the assembler unchanged, and pulses fifo_wr_ovf the next cycle.
REQ-020 fifo_wr_full is registered; it is 1 when level==DEPTH; a same-cycle pop does not make a write accepted while full=1.
REQ-021 Standard read: rd_en=1 with empty=0 pops one word; dout/strb/last update on the next clock edge and hold otherwise; rd_en with empty=1 is ignored.
REQ-022 Commit to fifo_rd_empty deassertion latency: 1 cycle (standard mode).
REQ-023 Simultaneous commit and pop: level unchanged; pop at level 1 with a same-cycle commit keeps empty=0.
REQ-024 Pointers wrap modulo DEPTH; level never exceeds DEPTH nor goes below 0.
REQ-025 Illegal DATA_BUS_WIDTH fails elaboration.

Reset
REQ-026 fifo_arst_n=0 immediately clears pointers, level, lane counter and assembler; a partially packed word is discarded.
REQ-027 Reset values: fifo_rd_dout=0, fifo_rd_strb=0, fifo_rd_last=0, fifo_rd_empty=1, fifo_wr_full=0, fifo_wr_ovf=0, fifo_rd_level=0.
REQ-028 fifo_arst_n deassertion is synchronous to fifo_clk, provided upstream; first write accepted on the first edge after release.

Configuration
REQ-029 Macro RFIFO_PACK_FWFT_EN defined: first-word fall-through; while empty=0, dout/strb/last already show the head word; rd_en pops it; the next word appears on the following edge; commit-to-empty-deassert latency is 2 cycles; level counts the word held in the output stage.
REQ-030 Macro undefined: standard read behaviour per REQ-021/022.

Verification
REQ-031 W=32: write 0xAAAA,0xBBBB,0xCCCC,0xDDDD (last on 0xDDDD) -> reads 0xBBBBAAAA strb=11 last=0, then 0xDDDDCCCC strb=11 last=1.
REQ-032 W=64: write 0x1111,0x2222,0x3333 with last on 0x3333 -> one word 0x0000333322221111, strb=0111, last=1, level=1.
REQ-033 W=16, DEPTH=4: five writes, no reads -> full=1 after 4th, 5th dropped, ovf pulses once, level=4; four reads return writes 1-4 in order, then empty=1.
REQ-034 Level=2, rd_en and a committing write in the same cycle -> level stays 2, data order preserved.
REQ-035 W=64: two halfwords written, reset pulsed, then 0x5555..0x8888 written with last on 0x8888 -> only 0x8888777766665555 is read.
REQ-036 FWFT build: single write 0xABCD with last at cycle t -> empty=0 at t+2, dout=0xABCD, strb=1, last=1 without rd_en; one rd_en -> empty=1.
